// File: rtl/sumador_segmentado.sv
// rtl/sumador_segmentado.sv - pipelined segmented ripple adder/subtractor with valid/ready flow control
// One SEG-bit ripple segment per stage; operands shrink and results grow as they move down the pipe.

module sumador_segmentado #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int PwrC  = 0
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             op,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int N = WIDTH / SEG;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             ci_eff;

    // The whole pipe moves in lockstep, so a single advance enable covers every stage.
    assign advance   = !valid_out || ready_in;
    assign ready_out = advance;
    assign b_eff     = op ? ~b : b;
    assign ci_eff    = op ? ~ci : ci;

    if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_params
        $error("sumador_segmentado: WIDTH must be a positive multiple of SEG");
    end

    if (PwrC != 0) begin : g_pwr_tagged
    end

    genvar k;
    for (k = 0; k < N; k++) begin : g_stage
        localparam int IW = WIDTH - k * SEG;
        localparam int RW = (k + 1) * SEG;

        logic [IW-1:0]  a_in;
        logic [IW-1:0]  b_in;
        logic           c_in;
        logic           v_in;
        logic [SEG:0]   sum;
        logic [RW-1:0]  r_next;
        logic [RW-1:0]  r_q;
        logic           c_q;
        logic           v_q;

        if (k == 0) begin : g_head
            assign a_in   = a;
            assign b_in   = b_eff;
            assign c_in   = ci_eff;
            assign v_in   = valid_in;
            assign r_next = sum[SEG-1:0];
        end else begin : g_body
            assign a_in   = g_stage[k-1].g_fwd.a_q;
            assign b_in   = g_stage[k-1].g_fwd.b_q;
            assign c_in   = g_stage[k-1].c_q;
            assign v_in   = g_stage[k-1].v_q;
            assign r_next = {sum[SEG-1:0], g_stage[k-1].r_q};
        end

        assign sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

        // Skew registers: only the not-yet-added upper operand segments travel on.
        if (k < N - 1) begin : g_fwd
            logic [IW-SEG-1:0] a_q;
            logic [IW-SEG-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!reset_L) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[IW-1:SEG];
                    b_q <= b_in[IW-1:SEG];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_L) begin
                r_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (advance) begin
                r_q <= r_next;
                c_q <= sum[SEG];
                v_q <= v_in;
            end
        end

        // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
        if (k == N - 1) begin : g_tail
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (!reset_L) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= sum[SEG] ^ (a_in[SEG-1] ^ b_in[SEG-1] ^ sum[SEG-1]);
                end
            end
        end
    end

    assign s         = g_stage[N-1].r_q;
    assign co        = g_stage[N-1].c_q;
    assign valid_out = g_stage[N-1].v_q;
    assign ovf       = g_stage[N-1].g_tail.ovf_q;

endmodule

// File: tb/tb_sumador_segmentado.sv
// tb/tb_sumador_segmentado.sv - randomized self-checking bench for sumador_segmentado
// Expected results come from integer arithmetic on the operands, queued in transfer order.

module tb_sumador_segmentado;
    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int N     = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             reset_L;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             op;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    int checks   = 0;
    int failures = 0;
    int out_count;

    logic [WIDTH+1:0] exp_q[$];
    logic             prev_stall;
    logic [WIDTH+1:0] prev_out;

    always #5 clk = ~clk;

    sumador_segmentado #(
        .WIDTH(WIDTH),
        .SEG  (SEG),
        .PwrC (0)
    ) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .op       (op),
        .valid_out(valid_out),
        .ready_in (ready_in),
        .s        (s),
        .co       (co),
        .ovf      (ovf)
    );

    // Returns {co, ovf, s} from plain unsigned/signed integer arithmetic.
    function automatic logic [WIDTH+1:0] ref_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                   input logic c, input logic o);
        longint     ux, uy, sx, sy, lc, res, lim, raw;
        logic [63:0] bits;
        logic        carry, v;
        ux  = longint'(x);
        uy  = longint'(y);
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        lc  = c ? 64'sd1 : 64'sd0;
        lim = longint'(1) <<< (WIDTH - 1);
        if (!o) begin
            raw   = ux + uy + lc;
            carry = (raw >= (longint'(1) <<< WIDTH));
            res   = sx + sy + lc;
        end else begin
            raw   = ux - uy - lc;
            carry = (ux >= uy + lc);
            res   = sx - sy - lc;
        end
        v    = (res > lim - 1) || (res < -lim);
        bits = raw;
        return {carry, v, bits[WIDTH-1:0]};
    endfunction

    task automatic run_cycle(input logic vi, input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                             input logic cii, input logic opi, input logic ri, output logic fired);
        logic [WIDTH+1:0] expv;
        logic             exp_ready;
        valid_in = vi;
        a        = ai;
        b        = bi;
        ci       = cii;
        op       = opi;
        ready_in = ri;
        @(negedge clk);
        exp_ready = !((valid_out === 1'b1) && !ri);
        checks++;
        if (ready_out !== exp_ready) begin
            failures++;
            $display("FAIL ready_out: got %b want %b (valid_out=%b ready_in=%b)", ready_out, exp_ready, valid_out, ri);
        end
        if (prev_stall) begin
            checks++;
            if (valid_out !== 1'b1 || {co, ovf, s} !== prev_out) begin
                failures++;
                $display("FAIL stall_hold: got v=%b {co,ovf,s}=%h want v=1 %h", valid_out, {co, ovf, s}, prev_out);
            end
        end
        if (valid_out === 1'b1 && ri) begin
            checks++;
            out_count++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got {co,ovf,s}=%h want no result", {co, ovf, s});
            end else begin
                expv = exp_q.pop_front();
                if ({co, ovf, s} !== expv) begin
                    failures++;
                    $display("FAIL result: got {co,ovf,s}=%h want %h", {co, ovf, s}, expv);
                end
            end
        end
        fired = vi && (ready_out === 1'b1);
        if (fired) exp_q.push_back(ref_model(ai, bi, cii, opi));
        prev_stall = (valid_out === 1'b1) && !ri;
        prev_out   = {co, ovf, s};
        @(posedge clk);
        #1;
    endtask

    // Single operation into an empty pipe; measures the cycle it surfaces in.
    task automatic latency_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic cii,
                              input logic opi, input logic [WIDTH+1:0] expv, input string name);
        int lat;
        a        = ai;
        b        = bi;
        ci       = cii;
        op       = opi;
        valid_in = 1'b1;
        ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1) begin
            failures++;
            $display("FAIL %s_accept: got ready_out=%b want 1", name, ready_out);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        lat      = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (lat != N) begin
            failures++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, N);
        end
        checks++;
        if ({co, ovf, s} !== expv) begin
            failures++;
            $display("FAIL %s_value: got {co,ovf,s}=%h want %h", name, {co, ovf, s}, expv);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] ra, rb;
        reset_L  = 1'b0;
        valid_in = 1'b1;
        ready_in = 1'b1;
        ci       = 1'b1;
        op       = 1'b0;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0 || s !== '0 || co !== 1'b0 || ovf !== 1'b0) begin
                failures++;
                $display("FAIL reset_state: got v=%b s=%h co=%b ovf=%b want all 0", valid_out, s, co, ovf);
            end
        end
        @(posedge clk);
        #1;
        reset_L  = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", ready_out);
        end
        @(posedge clk);
        #1;
        ra = WIDTH'($urandom);
        rb = WIDTH'($urandom);
        latency_op(ra, rb, 1'b0, 1'b0, ref_model(ra, rb, 1'b0, 1'b0), "reset_first_op");
    endtask

    task automatic test_add_carry();
        latency_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h0000}, "add_full_carry");
        latency_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}, "add_overflow");
    endtask

    task automatic test_subtract();
        latency_op(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}, "sub_borrow");
        latency_op(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, "sub_overflow");
    endtask

    task automatic test_back_to_back();
        logic fired;
        exp_q.delete();
        out_count  = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < 100; i++) begin
            run_cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b1, fired);
            checks++;
            if (!fired) begin
                failures++;
                $display("FAIL b2b_accept: op %0d got accepted=0 want 1", i);
            end
        end
        for (int i = 0; i < N; i++) begin
            run_cycle(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b1, fired);
        end
        checks++;
        if (out_count != 100 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: got %0d results (%0d pending) want 100 (0)", out_count, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic             fired, vi, cur_ci, cur_op;
        logic [WIDTH-1:0] cur_a, cur_b;
        int               sent, cycles;
        exp_q.delete();
        out_count  = 0;
        prev_stall = 1'b0;
        sent       = 0;
        cycles     = 0;
        vi         = 1'b0;
        cur_a      = '0;
        cur_b      = '0;
        cur_ci     = 1'b0;
        cur_op     = 1'b0;
        while (sent < 1000 && cycles < 20000) begin
            if (!vi) begin
                vi = ($urandom_range(0, 3) != 0);
                cur_a  = WIDTH'($urandom);
                cur_b  = WIDTH'($urandom);
                cur_ci = 1'($urandom);
                cur_op = 1'($urandom);
            end
            run_cycle(vi, cur_a, cur_b, cur_ci, cur_op, 1'($urandom_range(0, 1)), fired);
            if (fired) begin
                sent++;
                vi = 1'b0;
            end
            cycles++;
        end
        while (exp_q.size() != 0 && cycles < 25000) begin
            run_cycle(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'($urandom_range(0, 1)), fired);
            cycles++;
        end
        run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, fired);
        checks++;
        if (sent != 1000 || out_count != 1000 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_count: got sent=%0d results=%0d pending=%0d want 1000 1000 0", sent, out_count, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic             fired;
        logic [WIDTH-1:0] ra, rb;
        exp_q.delete();
        out_count  = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b1, fired);
        end
        reset_L  = 1'b0;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        reset_L  = 1'b1;
        valid_in = 1'b0;
        exp_q.delete();
        out_count  = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            run_cycle(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b1, fired);
        end
        checks++;
        if (out_count != 0) begin
            failures++;
            $display("FAIL midreset_discard: got %0d results want 0", out_count);
        end
        ra = WIDTH'($urandom);
        rb = WIDTH'($urandom);
        latency_op(ra, rb, 1'b1, 1'b1, ref_model(ra, rb, 1'b1, 1'b1), "midreset_first");
    endtask

    initial begin
        reset_L    = 1'b0;
        valid_in   = 1'b0;
        ready_in   = 1'b1;
        a          = '0;
        b          = '0;
        ci         = 1'b0;
        op         = 1'b0;
        prev_stall = 1'b0;
        prev_out   = '0;
        out_count  = 0;
        test_reset();
        test_add_carry();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
